// File: rtl/forth_loader.sv
// Boot/reload controller: holds the forth core in reset while a framed byte
// stream (A5, LEN, words hi-first, XOR checksum) is written into instruction RAM.
module forth_loader #(
  parameter int iaddr_width = 10
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [7:0]             rx_data,
  input  logic                   rx_valid,
  output logic                   rx_ready,
  output logic [iaddr_width-1:0] imem_waddr,
  output logic [15:0]            imem_wdata,
  output logic                   imem_we,
  output logic                   core_reset,
  output logic                   busy,
  output logic                   err
);

  typedef enum logic [2:0] {
    IDLE, LEN_H, LEN_L, DATA_H, DATA_L, WRITE, CSUM, RUN
  } state_t;

  localparam logic [16:0] MAX_LEN = 17'd1 << iaddr_width;

  state_t                 state_q, state_d;
  logic [7:0]             len_hi_q, len_hi_d;
  logic [15:0]            rem_q, rem_d;
  logic [iaddr_width-1:0] addr_q, addr_d;
  logic [7:0]             hi_q, hi_d;
  logic [7:0]             csum_q, csum_d;
  logic                   err_q, err_d;
  logic                   we_q, we_d;
  logic [iaddr_width-1:0] waddr_q, waddr_d;
  logic [15:0]            wdata_q, wdata_d;
  logic                   core_reset_q, core_reset_d;
  logic                   busy_q, busy_d;
  logic                   accept;
  logic [16:0]            len_full;

  assign rx_ready = !reset && (state_q != WRITE);
  assign accept   = rx_valid && rx_ready;
  assign len_full = {1'b0, len_hi_q, rx_data};

  always_comb begin
    state_d  = state_q;
    len_hi_d = len_hi_q;
    rem_d    = rem_q;
    addr_d   = addr_q;
    hi_d     = hi_q;
    csum_d   = csum_q;
    err_d    = err_q;
    we_d     = 1'b0;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;
    case (state_q)
      IDLE, RUN: begin
        // Anything other than a header is swallowed so the core never sees it.
        if (accept && rx_data == 8'hA5) begin
          state_d = LEN_H;
          err_d   = 1'b0;
          csum_d  = 8'h00;
          addr_d  = '0;
        end
      end
      LEN_H: if (accept) begin
        len_hi_d = rx_data;
        csum_d   = csum_q ^ rx_data;
        state_d  = LEN_L;
      end
      LEN_L: if (accept) begin
        csum_d = csum_q ^ rx_data;
        rem_d  = {len_hi_q, rx_data};
        if (len_full > MAX_LEN) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else if (len_full == 17'd0) begin
          state_d = CSUM;
        end else begin
          state_d = DATA_H;
        end
      end
      DATA_H: if (accept) begin
        hi_d    = rx_data;
        csum_d  = csum_q ^ rx_data;
        state_d = DATA_L;
      end
      DATA_L: if (accept) begin
        csum_d  = csum_q ^ rx_data;
        we_d    = 1'b1;
        waddr_d = addr_q;
        wdata_d = {hi_q, rx_data};
        state_d = WRITE;
      end
      WRITE: begin
        // A full-depth load wraps addr_q to 0 here but exits before writing again.
        addr_d  = addr_q + 1'b1;
        rem_d   = rem_q - 16'd1;
        state_d = (rem_q == 16'd1) ? CSUM : DATA_H;
      end
      CSUM: if (accept) begin
        if (rx_data == csum_q) begin
          state_d = RUN;
        end else begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    core_reset_d = (state_d != RUN);
    busy_d       = (state_d != IDLE) && (state_d != RUN);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      len_hi_q     <= 8'h00;
      rem_q        <= 16'h0000;
      addr_q       <= '0;
      hi_q         <= 8'h00;
      csum_q       <= 8'h00;
      err_q        <= 1'b0;
      we_q         <= 1'b0;
      waddr_q      <= '0;
      wdata_q      <= 16'h0000;
      core_reset_q <= 1'b1;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_hi_q     <= len_hi_d;
      rem_q        <= rem_d;
      addr_q       <= addr_d;
      hi_q         <= hi_d;
      csum_q       <= csum_d;
      err_q        <= err_d;
      we_q         <= we_d;
      waddr_q      <= waddr_d;
      wdata_q      <= wdata_d;
      core_reset_q <= core_reset_d;
      busy_q       <= busy_d;
    end
  end

  assign imem_we    = we_q;
  assign imem_waddr = waddr_q;
  assign imem_wdata = wdata_q;
  assign core_reset = core_reset_q;
  assign busy       = busy_q;
  assign err        = err_q;

endmodule

// File: tb/tb_forth_loader.sv
// Directed frames against a frame-level model of the loader; a negedge
// monitor checks every RAM write against the model's expected write list.
module tb_forth_loader;
  localparam int IW    = 10;
  localparam int DEPTH = 1 << IW;

  logic          clk = 1'b0;
  logic          reset;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          rx_ready;
  logic [IW-1:0] imem_waddr;
  logic [15:0]   imem_wdata;
  logic          imem_we;
  logic          core_reset;
  logic          busy;
  logic          err;

  forth_loader #(.iaddr_width(IW)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
    .imem_we(imem_we), .core_reset(core_reset), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [7:0]  fq[$];
  logic [31:0] exp_q[$];
  logic        m_err = 1'b0;
  logic        m_run = 1'b0;
  int          wr_count = 0;
  logic [31:0] last_wr = '0;
  int          stalls = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Frame-level model: parse header/length/words/checksum from the byte list.
  task automatic model_frame();
    int i = 0;
    logic [15:0] len;
    logic [7:0]  cs;
    while (i < fq.size() && fq[i] != 8'hA5) i++;
    if (i >= fq.size()) return;
    m_err = 1'b0;
    m_run = 1'b0;
    len = {fq[i+1], fq[i+2]};
    cs  = fq[i+1] ^ fq[i+2];
    i += 3;
    if (int'(len) > DEPTH) begin
      m_err = 1'b1;
      return;
    end
    for (int w = 0; w < int'(len); w++) begin
      exp_q.push_back({16'(w), fq[i], fq[i+1]});
      cs ^= fq[i] ^ fq[i+1];
      i += 2;
    end
    if (i < fq.size()) begin
      if (fq[i] == cs) m_run = 1'b1;
      else m_err = 1'b1;
    end
  endtask

  // Starts and ends on a negedge; returns on the negedge after acceptance.
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    rx_valid = 1'b1;
    rx_data  = b;
    while (!rx_ready && n < 50) begin
      stalls++;
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("handshake_timeout", 32'(n), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic run_frame(input string name);
    model_frame();
    stalls = 0;
    for (int i = 0; i < fq.size(); i++) begin
      send_byte(fq[i]);
      if (i == 0 && fq[0] == 8'hA5) check({name, "_hdr_core_reset"}, 32'(core_reset), 32'd1);
    end
    check({name, "_err"}, 32'(err), 32'(m_err));
    check({name, "_core_reset"}, 32'(core_reset), 32'(!m_run));
    check({name, "_busy"}, 32'(busy), 32'd0);
    check({name, "_pending_writes"}, 32'(exp_q.size()), 32'd0);
  endtask

  // Write monitor: every strobe must match the model, and only in the write cycle.
  always @(negedge clk) begin
    if (!reset && imem_we) begin
      wr_count++;
      last_wr = {6'b0, imem_waddr, imem_wdata};
      check("we_in_write_cycle", 32'(rx_ready), 32'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_write", last_wr, 32'hFFFF_FFFF);
      end else begin
        check("write", last_wr, exp_q.pop_front());
      end
    end
    if (!reset) check("busy_implies_core_reset", 32'(busy && !core_reset), 32'd0);
  end

  initial begin
    logic [7:0] cs;
    logic [15:0] wd;
    reset = 1'b1;
    rx_valid = 1'b0;
    rx_data = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_rx_ready", 32'(rx_ready), 32'd0);
    check("rst_outputs", {26'(imem_waddr), 1'b0, imem_we, core_reset, busy, err, 1'b0},
          {26'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
    check("rst_wdata", 32'(imem_wdata), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("idle_rx_ready", 32'(rx_ready), 32'd1);

    // Good single word
    wr_count = 0;
    fq = {8'hA5, 8'h00, 8'h01, 8'h12, 8'h34, 8'h27};
    run_frame("single");
    check("single_lit_write", last_wr, {16'h0000, 16'h1234});
    check("single_lit_core_reset", 32'(core_reset), 32'd0);
    check("single_wr_count", 32'(wr_count), 32'd1);

    // Two words back-to-back; XOR 00^02^AB^CD^00^01 = 65
    wr_count = 0;
    fq = {8'hA5, 8'h00, 8'h02, 8'hAB, 8'hCD, 8'h00, 8'h01, 8'h65};
    run_frame("two");
    check("two_stalls", 32'(stalls), 32'd2);
    check("two_last_write", last_wr, {16'h0001, 16'h0001});
    check("two_lit_running", 32'(core_reset), 32'd0);

    // Bad checksum, then recovery
    fq = {8'hA5, 8'h00, 8'h01, 8'h12, 8'h34, 8'h28};
    run_frame("badcs");
    check("badcs_lit_err", 32'(err), 32'd1);
    check("badcs_lit_write", last_wr, {16'h0000, 16'h1234});
    fq = {8'hA5, 8'h00, 8'h01, 8'h12, 8'h34, 8'h27};
    run_frame("recover");
    check("recover_lit_err", 32'(err), 32'd0);

    // Length one past depth
    wr_count = 0;
    fq = {8'hA5, 8'h04, 8'h01};
    run_frame("toolong");
    check("toolong_lit_err", 32'(err), 32'd1);
    repeat (3) @(negedge clk);
    check("toolong_no_write", 32'(wr_count), 32'd0);

    // Zero length
    fq = {8'hA5, 8'h00, 8'h00, 8'h00};
    run_frame("zero");
    check("zero_no_write", 32'(wr_count), 32'd0);

    // Full depth load
    fq = {8'hA5, 8'h04, 8'h00};
    cs = 8'h04;
    for (int w = 0; w < DEPTH; w++) begin
      wd = 16'(w * 37 + 5);
      fq.push_back(wd[15:8]);
      fq.push_back(wd[7:0]);
      cs ^= wd[15:8] ^ wd[7:0];
    end
    fq.push_back(cs);
    run_frame("full");
    check("full_wr_count", 32'(wr_count), 32'(DEPTH));
    check("full_last_addr", 32'(last_wr[31:16]), 32'h3FF);

    // Junk while running, then reload
    fq = {8'h11};
    run_frame("junk");
    check("junk_lit_running", 32'(core_reset), 32'd0);
    fq = {8'hA5, 8'h00, 8'h01, 8'h00, 8'h05, 8'h04};
    run_frame("reload");
    check("reload_lit_write", last_wr, {16'h0000, 16'h0005});

    // Reset mid-frame
    wr_count = 0;
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h02); send_byte(8'h12);
    check("mid_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_rx_ready", 32'(rx_ready), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    check("mid_outputs", {imem_we, core_reset, busy, err}, {1'b0, 1'b1, 1'b0, 1'b0});
    check("mid_addr_data", {6'b0, imem_waddr, imem_wdata}, 32'd0);
    send_byte(8'h34); send_byte(8'h56); send_byte(8'h00);
    repeat (3) @(negedge clk);
    check("mid_no_write", 32'(wr_count), 32'd0);
    check("mid_junk_busy", 32'(busy), 32'd0);
    check("mid_junk_core_reset", 32'(core_reset), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
